// File: rtl/ddr3_traffic_checker.sv
// Write-then-verify memory self-test driving the ddr3_controller user port.
// Define TRAFFIC_LFSR_EN for an LFSR data pattern instead of address^SEED.
module ddr3_traffic_checker #(
  parameter int                    ADDR_WIDTH  = 26,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR  = 'h1000,
  parameter int                    NUM_WORDS   = 64,
  parameter int                    STRIDE      = 1,
  parameter logic [DATA_WIDTH-1:0] SEED        = 'hA55A,
  parameter int                    TIMEOUT_CYC = 20,
  parameter int                    REFRESH_CYC = 0
) (
  input  logic                  pclk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  busy,
  input  logic                  data_ready,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  rd,
  output logic                  wr,
  output logic                  refresh,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_WAIT,
    S_W_CMD,
    S_W_GAP,
    S_R_WAIT,
    S_R_CMD,
    S_R_DATA,
    S_DONE
  } state_t;

  state_t state, nxt;

  logic [IW-1:0]         idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [TW-1:0]         tmr;
  logic [DATA_WIDTH-1:0] exp_word;
  logic                  ref_pend;
  logic                  ref_exp;
  logic                  ref_ack;
  logic                  ld_cmd;
  logic                  arm;
  logic                  phase_rst;
  logic                  step;
  logic                  err_hit;
  logic                  last;
  logic                  tmr_hit;

  assign last    = (idx == IW'(NUM_WORDS - 1));
  assign tmr_hit = (tmr == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= nxt;
  end

  always_comb begin
    nxt       = state;
    wr        = 1'b0;
    rd        = 1'b0;
    refresh   = 1'b0;
    ref_ack   = 1'b0;
    ld_cmd    = 1'b0;
    arm       = 1'b0;
    phase_rst = 1'b0;
    step      = 1'b0;
    err_hit   = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          arm       = 1'b1;
          phase_rst = 1'b1;
          nxt       = S_W_WAIT;
        end
      end
      S_W_WAIT: begin
        if (!busy) begin
          if (ref_pend) begin
            refresh = 1'b1;
            ref_ack = 1'b1;
          end else begin
            ld_cmd = 1'b1;
            nxt    = S_W_CMD;
          end
        end
      end
      S_W_CMD: begin
        wr  = 1'b1;
        nxt = S_W_GAP;
      end
      S_W_GAP: begin
        if (last) begin
          phase_rst = 1'b1;
          nxt       = S_R_WAIT;
        end else begin
          step = 1'b1;
          nxt  = S_W_WAIT;
        end
      end
      S_R_WAIT: begin
        if (!busy) begin
          if (ref_pend) begin
            refresh = 1'b1;
            ref_ack = 1'b1;
          end else begin
            ld_cmd = 1'b1;
            nxt    = S_R_CMD;
          end
        end
      end
      S_R_CMD: begin
        rd  = 1'b1;
        nxt = S_R_DATA;
      end
      S_R_DATA: begin
        // data_ready wins over a timeout landing on the same cycle
        if (data_ready || tmr_hit) begin
          err_hit = !data_ready || (dout != exp_word);
          if (last) begin
            nxt = S_DONE;
          end else begin
            step = 1'b1;
            nxt  = S_R_WAIT;
          end
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign running = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);
  assign pass    = done && (err_count == 16'h0);

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      idx            <= '0;
      cur_addr       <= START_ADDR;
      tmr            <= '0;
      addr           <= '0;
      din            <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      if (phase_rst) begin
        idx      <= '0;
        cur_addr <= START_ADDR;
      end else if (step) begin
        idx      <= idx + IW'(1);
        cur_addr <= cur_addr + ADDR_WIDTH'(STRIDE);
      end
      if (ld_cmd) begin
        addr <= cur_addr;
        if (state == S_W_WAIT) din <= exp_word;
      end
      if (state != S_R_DATA) tmr <= '0;
      else                   tmr <= tmr + TW'(1);
      if (arm) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (err_hit) begin
        if (err_count == 16'h0)    first_err_addr <= cur_addr;
        if (err_count != 16'hFFFF) err_count      <= err_count + 16'h1;
      end
    end
  end

  // a fresh expiry on the service cycle keeps the flag set
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) ref_pend <= 1'b0;
    else         ref_pend <= ref_exp | (ref_pend & ~ref_ack);
  end

  if (REFRESH_CYC > 0) begin : g_ref
    localparam int RW = $clog2(REFRESH_CYC + 1);
    logic [RW-1:0] rtmr;
    assign ref_exp = (rtmr == RW'(REFRESH_CYC - 1));
    always_ff @(posedge pclk or negedge resetn) begin
      if (!resetn)      rtmr <= '0;
      else if (ref_exp) rtmr <= '0;
      else              rtmr <= rtmr + RW'(1);
    end
  end else begin : g_noref
    assign ref_exp = 1'b0;
  end

`ifdef TRAFFIC_LFSR_EN
  localparam logic [DATA_WIDTH-1:0] SEED_NZ =
    (SEED == '0) ? DATA_WIDTH'(1) : SEED;
  localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(16'hB400);
  logic [DATA_WIDTH-1:0] lfsr;
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn)        lfsr <= SEED_NZ;
    else if (phase_rst) lfsr <= SEED_NZ;
    else if (step)
      lfsr <= {1'b0, lfsr[DATA_WIDTH-1:1]} ^ (lfsr[0] ? TAPS : '0);
  end
  assign exp_word = lfsr;
`else
  assign exp_word = DATA_WIDTH'(cur_addr) ^ SEED;
`endif

endmodule
